fetch_ctrl: RTL and testbench

Sequencer for the fetch stage PC datapath. Each cycle it drives the fetch stage's `PCWrite_F`/`PCTarget` pair to implement boot hold, stall (PC hold), branch/jump redirect and halt. It also issues IF/ID and ID/EX flushes and keeps a fetched-instruction counter. It sits between the hazard unit / execute stage and the fetch stage.

---
 rtl/fetch_ctrl.sv | 111 +++++++++++
 tb/tb_fetch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage PC sequencer: boot hold, stall, redirect, halt, fetch counter
// Misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl #(
   parameter logic [63:0] RESET_VEC   = 64'h0,
   parameter int          BOOT_CYCLES = 2,
   parameter logic [63:0] TRAP_VEC    = 64'h100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] PC_F,
   input  logic        stall_F,
   input  logic        branch_taken_E,
   input  logic [63:0] branch_target_E,
   input  logic        halt_req,
   input  logic        resume,
   output logic        PCWrite_F,
   output logic [63:0] PCTarget,
   output logic        flush_D,
   output logic        flush_E,
   output logic        fetch_valid,
   output logic        halted,
   output logic [63:0] fetch_count,
   output logic        misalign_flag
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam int          BOOT_LEN  = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
   localparam logic [31:0] BOOT_LAST = 32'(BOOT_LEN - 1);

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   logic [1:0]  state_q, state_d;
   logic [31:0] boot_cnt_q, boot_cnt_d;
   logic [63:0] fetch_count_q, fetch_count_d;
   logic        misalign_q, misalign_d;
   logic        misaligned;
   logic [63:0] redirect_pc;

   // Without the trap, low target bits are simply dropped to keep fetch word-aligned.
   assign misaligned  = TRAP_EN && (branch_target_E[1:0] != 2'b00);
   assign redirect_pc = misaligned ? TRAP_VEC : {branch_target_E[63:2], 2'b00};

   always_comb begin
      state_d     = state_q;
      boot_cnt_d  = boot_cnt_q;
      misalign_d  = 1'b0;
      PCWrite_F   = 1'b1;
      PCTarget    = PC_F;
      flush_D     = 1'b0;
      flush_E     = 1'b0;
      fetch_valid = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (halt_req) begin
               flush_D = 1'b1;
               state_d = ST_HALT;
            end else if (branch_taken_E) begin
               PCTarget   = redirect_pc;
               flush_D    = 1'b1;
               flush_E    = 1'b1;
               misalign_d = misaligned;
            end else if (!stall_F) begin
               PCWrite_F   = 1'b0;
               PCTarget    = PC_F + 64'd4;
               fetch_valid = 1'b1;
            end
         end
         ST_HALT: begin
            // Resume cycle still holds PC; sequential fetch restarts next cycle.
            flush_D = 1'b1;
            if (resume && !halt_req) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            PCTarget   = RESET_VEC;
            flush_D    = 1'b1;
            flush_E    = 1'b1;
            boot_cnt_d = boot_cnt_q + 32'd1;
            state_d    = (boot_cnt_q == BOOT_LAST) ? ST_RUN : ST_BOOT;
         end
      endcase
      fetch_count_d = fetch_count_q + {63'd0, fetch_valid};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_BOOT;
         boot_cnt_q    <= 32'd0;
         fetch_count_q <= 64'd0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         boot_cnt_q    <= boot_cnt_d;
         fetch_count_q <= fetch_count_d;
         misalign_q    <= misalign_d;
      end
   end

   assign halted        = (state_q == ST_HALT);
   assign fetch_count   = fetch_count_q;
   assign misalign_flag = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a behavioural fetch-stage model
module tb_fetch_ctrl;

   localparam logic [63:0] RESET_VEC   = 64'h0;
   localparam logic [63:0] TRAP_VEC    = 64'h100;
   localparam int          BOOT_CYCLES = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit TRAP_ON = 1'b1;
`else
   localparam bit TRAP_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] PC_F = 64'd0;
   logic        stall_F = 1'b0;
   logic        branch_taken_E = 1'b0;
   logic [63:0] branch_target_E = 64'd0;
   logic        halt_req = 1'b0;
   logic        resume = 1'b0;
   logic        PCWrite_F;
   logic [63:0] PCTarget;
   logic        flush_D;
   logic        flush_E;
   logic        fetch_valid;
   logic        halted;
   logic [63:0] fetch_count;
   logic        misalign_flag;

   int tests  = 0;
   int failed = 0;

   // Behavioural model: cycles of boot left, halted flag, counter, pending trap pulse, fetch PC.
   int          boot_left;
   bit          m_halted, m_mis;
   logic [63:0] m_count, m_pc;
   bit          e_pcw, e_fd, e_fe, e_fv;
   logic [63:0] e_tgt;

   fetch_ctrl #(.RESET_VEC(RESET_VEC), .BOOT_CYCLES(BOOT_CYCLES), .TRAP_VEC(TRAP_VEC)) dut (
      .clk(clk), .rst(rst), .PC_F(PC_F), .stall_F(stall_F),
      .branch_taken_E(branch_taken_E), .branch_target_E(branch_target_E),
      .halt_req(halt_req), .resume(resume), .PCWrite_F(PCWrite_F), .PCTarget(PCTarget),
      .flush_D(flush_D), .flush_E(flush_E), .fetch_valid(fetch_valid), .halted(halted),
      .fetch_count(fetch_count), .misalign_flag(misalign_flag)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      boot_left = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
      m_halted  = 1'b0;
      m_mis     = 1'b0;
      m_count   = 64'd0;
      m_pc      = RESET_VEC;
   endtask

   task automatic model_eval();
      e_pcw = 1'b1; e_tgt = m_pc; e_fd = 1'b0; e_fe = 1'b0; e_fv = 1'b0;
      if (boot_left > 0) begin
         e_tgt = RESET_VEC; e_fd = 1'b1; e_fe = 1'b1;
      end else if (m_halted || halt_req) begin
         e_fd = 1'b1;
      end else if (branch_taken_E) begin
         e_fd = 1'b1; e_fe = 1'b1;
         if (TRAP_ON && (branch_target_E % 4 != 0)) e_tgt = TRAP_VEC;
         else e_tgt = branch_target_E - (branch_target_E % 4);
      end else if (!stall_F) begin
         e_pcw = 1'b0; e_tgt = m_pc + 64'd4; e_fv = 1'b1;
      end
   endtask

   task automatic model_step();
      bit run_now;
      run_now = (boot_left == 0) && !m_halted;
      m_mis   = TRAP_ON && run_now && !halt_req && branch_taken_E && (branch_target_E % 4 != 0);
      m_pc    = e_tgt;
      if (e_fv) m_count = m_count + 64'd1;
      if (boot_left > 0) boot_left = boot_left - 1;
      else if (m_halted) begin
         if (resume && !halt_req) m_halted = 1'b0;
      end else if (halt_req) m_halted = 1'b1;
   endtask

   task automatic drive(input bit st, input bit br, input logic [63:0] tg, input bit hr, input bit rs);
      stall_F = st; branch_taken_E = br; branch_target_E = tg; halt_req = hr; resume = rs;
      PC_F = m_pc;
      #1;
      model_eval();
   endtask

   task automatic advance();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      drive(1'b1, 1'b1, 64'h300, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      tests++; if (PCWrite_F !== 1'b1) begin failed++; $display("FAIL rst_pcw got %b exp 1", PCWrite_F); end
      tests++; if (PCTarget !== RESET_VEC) begin failed++; $display("FAIL rst_tgt got %h exp %h", PCTarget, RESET_VEC); end
      tests++; if ({flush_D, flush_E} !== 2'b11) begin failed++; $display("FAIL rst_flush got %b exp 11", {flush_D, flush_E}); end
      tests++; if (fetch_valid !== 1'b0) begin failed++; $display("FAIL rst_fv got %b exp 0", fetch_valid); end
      tests++; if ({halted, misalign_flag} !== 2'b00) begin failed++; $display("FAIL rst_flags got %b exp 00", {halted, misalign_flag}); end
      tests++; if (fetch_count !== 64'd0) begin failed++; $display("FAIL rst_count got %0d exp 0", fetch_count); end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 1) == 1, 1'b0);
         tests++; if (PCWrite_F !== 1'b1 || PCTarget !== 64'h0 || fetch_valid !== 1'b0) begin
            failed++; $display("FAIL boot_hold cyc %0d got pcw=%b tgt=%h fv=%b exp 1/0/0", i, PCWrite_F, PCTarget, fetch_valid);
         end
         advance();
      end
      drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tests++; if (PCWrite_F !== 1'b0 || fetch_valid !== 1'b1) begin
         failed++; $display("FAIL boot_exit got pcw=%b fv=%b exp 0/1", PCWrite_F, fetch_valid);
      end
      advance();
      tests++; if (fetch_count !== 64'd1) begin failed++; $display("FAIL boot_count got %0d exp 1", fetch_count); end
   endtask

   task automatic test_stall();
      logic [63:0] cnt0;
      cnt0 = m_count;
      m_pc = 64'h40;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
         tests++; if (PCWrite_F !== 1'b1 || PCTarget !== 64'h40) begin
            failed++; $display("FAIL stall_hold cyc %0d got pcw=%b tgt=%h exp 1/40", i, PCWrite_F, PCTarget);
         end
         tests++; if ({flush_D, flush_E, fetch_valid} !== 3'b000 || fetch_count !== cnt0) begin
            failed++; $display("FAIL stall_ctl cyc %0d got fl/fv=%b cnt=%0d exp 000/%0d", i, {flush_D, flush_E, fetch_valid}, fetch_count, cnt0);
         end
         advance();
      end
      drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tests++; if (PCWrite_F !== 1'b0 || fetch_valid !== 1'b1 || PCTarget !== 64'h44) begin
         failed++; $display("FAIL stall_release got pcw=%b fv=%b tgt=%h exp 0/1/44", PCWrite_F, fetch_valid, PCTarget);
      end
      advance();
   endtask

   task automatic test_branch_over_stall();
      m_pc = 64'h80;
      drive(1'b1, 1'b1, 64'h200, 1'b0, 1'b0);
      tests++; if (PCWrite_F !== 1'b1 || PCTarget !== 64'h200) begin
         failed++; $display("FAIL br_tgt got pcw=%b tgt=%h exp 1/200", PCWrite_F, PCTarget);
      end
      tests++; if ({flush_D, flush_E, fetch_valid} !== 3'b110) begin
         failed++; $display("FAIL br_flush got %b exp 110", {flush_D, flush_E, fetch_valid});
      end
      advance();
      drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tests++; if ({flush_D, flush_E, fetch_valid} !== 3'b001 || PCTarget !== 64'h204) begin
         failed++; $display("FAIL br_after got fl/fv=%b tgt=%h exp 001/204", {flush_D, flush_E, fetch_valid}, PCTarget);
      end
      advance();
   endtask

   task automatic test_halt();
      m_pc = 64'h90;
      drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      tests++; if (PCWrite_F !== 1'b1 || PCTarget !== 64'h90 || flush_D !== 1'b1 || fetch_valid !== 1'b0 || halted !== 1'b0) begin
         failed++; $display("FAIL halt_req got pcw=%b tgt=%h fd=%b fv=%b h=%b exp 1/90/1/0/0", PCWrite_F, PCTarget, flush_D, fetch_valid, halted);
      end
      advance();
      drive(1'b0, 1'b1, 64'h300, 1'b0, 1'b0);
      tests++; if (halted !== 1'b1 || PCTarget !== 64'h90 || flush_E !== 1'b0 || fetch_valid !== 1'b0) begin
         failed++; $display("FAIL halt_br got h=%b tgt=%h fe=%b fv=%b exp 1/90/0/0", halted, PCTarget, flush_E, fetch_valid);
      end
      advance();
      drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
      advance();
      drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
      tests++; if (halted !== 1'b1 || PCWrite_F !== 1'b1 || PCTarget !== 64'h90) begin
         failed++; $display("FAIL halt_resume got h=%b pcw=%b tgt=%h exp 1/1/90", halted, PCWrite_F, PCTarget);
      end
      advance();
      drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tests++; if (halted !== 1'b0 || PCWrite_F !== 1'b0 || fetch_valid !== 1'b1 || PCTarget !== 64'h94) begin
         failed++; $display("FAIL halt_restart got h=%b pcw=%b fv=%b tgt=%h exp 0/0/1/94", halted, PCWrite_F, fetch_valid, PCTarget);
      end
      advance();
   endtask

   task automatic test_misalign();
      logic [63:0] exp_tgt;
      exp_tgt = TRAP_ON ? 64'h100 : 64'h200;
      m_pc = 64'hA0;
      drive(1'b0, 1'b1, 64'h202, 1'b0, 1'b0);
      tests++; if (PCTarget !== exp_tgt || {flush_D, flush_E} !== 2'b11 || misalign_flag !== 1'b0) begin
         failed++; $display("FAIL mis_tgt got tgt=%h fl=%b mf=%b exp %h/11/0", PCTarget, {flush_D, flush_E}, misalign_flag, exp_tgt);
      end
      advance();
      drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tests++; if (misalign_flag !== TRAP_ON) begin failed++; $display("FAIL mis_pulse got %b exp %b", misalign_flag, TRAP_ON); end
      advance();
      drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tests++; if (misalign_flag !== 1'b0) begin failed++; $display("FAIL mis_clear got %b exp 0", misalign_flag); end
      advance();
   endtask

   task automatic test_pc_wrap();
      m_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      tests++; if (PCTarget !== 64'h0) begin failed++; $display("FAIL pc_wrap got %h exp 0", PCTarget); end
      advance();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, {$urandom, $urandom},
               $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
         tests++; if (PCWrite_F !== e_pcw || (e_pcw && PCTarget !== e_tgt)) begin
            failed++; $display("FAIL rnd_pc cyc %0d got pcw=%b tgt=%h exp %b/%h", i, PCWrite_F, PCTarget, e_pcw, e_tgt);
         end
         tests++; if ({flush_D, flush_E, fetch_valid} !== {e_fd, e_fe, e_fv}) begin
            failed++; $display("FAIL rnd_ctl cyc %0d got %b exp %b", i, {flush_D, flush_E, fetch_valid}, {e_fd, e_fe, e_fv});
         end
         tests++; if (halted !== m_halted || misalign_flag !== m_mis || fetch_count !== m_count) begin
            failed++; $display("FAIL rnd_reg cyc %0d got h=%b mf=%b cnt=%0d exp %b/%b/%0d", i, halted, misalign_flag, fetch_count, m_halted, m_mis, m_count);
         end
         advance();
      end
   endtask

   task automatic test_async_reset();
      rst = 1'b0;
      model_reset();
      drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < BOOT_CYCLES + 25; i++) begin
         drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
         advance();
      end
      tests++; if (fetch_count !== 64'd25) begin failed++; $display("FAIL ar_count_pre got %0d exp 25", fetch_count); end
      drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      advance();
      tests++; if (halted !== 1'b1) begin failed++; $display("FAIL ar_halted_pre got %b exp 1", halted); end
      #2;
      rst = 1'b0;
      #1;
      tests++; if (fetch_count !== 64'd0 || halted !== 1'b0 || PCTarget !== 64'h0 || PCWrite_F !== 1'b1) begin
         failed++; $display("FAIL ar_clear got cnt=%0d h=%b tgt=%h pcw=%b exp 0/0/0/1", fetch_count, halted, PCTarget, PCWrite_F);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_stall();
      test_branch_over_stall();
      test_halt();
      test_misalign();
      test_pc_wrap();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
